// File: rtl/time_display_scan_if.sv
`default_nettype none
//==============================================================================
// Module      : time_display_scan_if
// Description : Time-field inputs and multiplexed 7-segment display outputs
//               of time_display_scan, bundled as one interface.
// Revision    : 1.0 - initial release
//==============================================================================
interface time_display_scan_if;
   logic [7:0]  Hours_i;
   logic [7:0]  Minutes_i;
   logic [7:0]  Seconds_i;
   logic [11:0] Milli_i;
   logic        blank_i;
   logic [7:0]  an_o;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic        busy_o;

   // Time source / display consumer side
   modport master (
      output Hours_i, Minutes_i, Seconds_i, Milli_i, blank_i,
      input  an_o, seg_o, dp_o, busy_o
   );

   // Display driver side
   modport slave (
      input  Hours_i, Minutes_i, Seconds_i, Milli_i, blank_i,
      output an_o, seg_o, dp_o, busy_o
   );
endinterface
`default_nettype wire

// File: rtl/time_display_scan.sv
`default_nettype none
//==============================================================================
// Module      : time_display_scan
// Description : Samples binary HH/MM/SS/ms fields, converts them to BCD with a
//               sequential shift-add-3 engine, and scans the result onto an
//               8-digit multiplexed 7-segment display as HH.MM.SS.mm.
//               Optional macro LEADING_ZERO_BLANK_EN blanks a zero hours-tens
//               digit.
// Revision    : 1.0 - initial release
//==============================================================================
module time_display_scan #(
   parameter int SCAN_DIV    = 100_000,
   parameter int CONV_PERIOD = 1_000_000
) (
   input  logic               clk,
   input  logic               reset,
   time_display_scan_if.slave bus
);

   localparam int c_SCAN_W   = $clog2(SCAN_DIV);
   localparam int c_SAMPLE_W = $clog2(CONV_PERIOD);
   localparam logic [c_SCAN_W-1:0]   c_SCAN_LAST   = c_SCAN_W'(SCAN_DIV - 1);
   localparam logic [c_SAMPLE_W-1:0] c_SAMPLE_LAST = c_SAMPLE_W'(CONV_PERIOD - 1);
   localparam logic [3:0] c_SHIFT_LAST = 4'd11;
   localparam logic [3:0] c_CODE_DASH  = 4'hA;   // display-register code for '-'
   localparam logic [6:0] c_SEG_BLANK  = 7'h7F;
   localparam logic [6:0] c_SEG_DASH   = 7'b0111111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Add 3 to every BCD nibble that is 5 or more (the pre-shift correction).
   function automatic logic [15:0] f_add3(input logic [15:0] bcd);
      logic [15:0] w_res;
      for (int i = 0; i < 4; i++) begin
         w_res[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
      end
      return w_res;
   endfunction

   logic [c_SAMPLE_W-1:0] r_sample_cnt;
   logic                  w_sample_tick;
   state_t                r_state;
   state_t                w_state_next;
   logic                  w_busy;
   logic                  w_capture;
   logic                  w_load;
   logic                  w_shift;
   logic                  w_commit;
   logic [3:0]            r_shift_cnt;
   // Field order in the engine: 0 = hours, 1 = minutes, 2 = seconds, 3 = ms
   logic [3:0][11:0]      r_bin;
   logic [3:0][15:0]      r_bcd;
   logic [3:0]            r_oor;
   logic [3:0][11:0]      w_bin_in;
   logic [3:0]            w_oor_in;
   logic [3:0][11:0]      w_bin_step;
   logic [3:0][15:0]      w_bcd_step;
   logic [7:0][3:0]       r_disp;
   logic [7:0][3:0]       w_disp_new;
   logic [c_SCAN_W-1:0]   r_scan_cnt;
   logic                  w_scan_tick;
   logic [2:0]            r_digit_idx;
   logic [3:0]            w_digit;
   logic [6:0]            w_seg_code;
   logic                  w_dp_code;
   logic [7:0]            r_an;
   logic [6:0]            r_seg;
   logic                  r_dp;

   assign w_sample_tick = (r_sample_cnt == c_SAMPLE_LAST);
   assign w_scan_tick   = (r_scan_cnt == c_SCAN_LAST);

   // Free-running sample period counter; terminal count is the sample tick.
   always_ff @(posedge clk) begin
      if (reset)              r_sample_cnt <= '0;
      else if (w_sample_tick) r_sample_cnt <= '0;
      else                    r_sample_cnt <= r_sample_cnt + 1'b1;
   end

   // Conversion FSM state register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // Conversion FSM next state and control strobes; busy covers LOAD..DONE.
   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b1;
      w_capture    = 1'b0;
      w_load       = 1'b0;
      w_shift      = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (w_sample_tick) begin
               w_capture    = 1'b1;
               w_state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_load       = 1'b1;
            w_state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            w_shift = 1'b1;
            if (r_shift_cnt == c_SHIFT_LAST) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            w_commit     = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_busy       = 1'b0;
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // 8-bit fields are zero-extended so all four share one 12-bit engine shape.
   assign w_bin_in[0] = {4'd0, bus.Hours_i};
   assign w_bin_in[1] = {4'd0, bus.Minutes_i};
   assign w_bin_in[2] = {4'd0, bus.Seconds_i};
   assign w_bin_in[3] = bus.Milli_i;
   assign w_oor_in[0] = (bus.Hours_i   > 8'd99);
   assign w_oor_in[1] = (bus.Minutes_i > 8'd99);
   assign w_oor_in[2] = (bus.Seconds_i > 8'd99);
   assign w_oor_in[3] = (bus.Milli_i   > 12'd999);

   // One shift-add-3 step per field: correct nibbles, then shift {bcd,bin} left.
   for (genvar g = 0; g < 4; g++) begin : g_field
      logic [15:0] w_add;
      logic        w_unused_msb;
      assign w_add         = f_add3(r_bcd[g]);
      assign w_bcd_step[g] = {w_add[14:0], r_bin[g][11]};
      assign w_bin_step[g] = {r_bin[g][10:0], 1'b0};
      assign w_unused_msb  = w_add[15];
   end

   // Conversion datapath: capture on the tick, clear BCD in LOAD, shift in SHIFT.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bin       <= '0;
         r_bcd       <= '0;
         r_oor       <= '0;
         r_shift_cnt <= '0;
      end else begin
         if (w_capture) begin
            r_bin <= w_bin_in;
            r_oor <= w_oor_in;
         end
         if (w_load) begin
            r_bcd       <= '0;
            r_shift_cnt <= '0;
         end
         if (w_shift) begin
            r_bin       <= w_bin_step;
            r_bcd       <= w_bcd_step;
            r_shift_cnt <= r_shift_cnt + 4'd1;
         end
      end
   end

   // Map converted fields onto the eight digit slots, dashing out-of-range fields.
   always_comb begin
      w_disp_new    = '0;
      w_disp_new[7] = r_oor[0] ? c_CODE_DASH : r_bcd[0][7:4];
      w_disp_new[6] = r_oor[0] ? c_CODE_DASH : r_bcd[0][3:0];
      w_disp_new[5] = r_oor[1] ? c_CODE_DASH : r_bcd[1][7:4];
      w_disp_new[4] = r_oor[1] ? c_CODE_DASH : r_bcd[1][3:0];
      w_disp_new[3] = r_oor[2] ? c_CODE_DASH : r_bcd[2][7:4];
      w_disp_new[2] = r_oor[2] ? c_CODE_DASH : r_bcd[2][3:0];
      w_disp_new[1] = r_oor[3] ? c_CODE_DASH : r_bcd[3][11:8];
      w_disp_new[0] = r_oor[3] ? c_CODE_DASH : r_bcd[3][7:4];
   end

   // Hundreds of H/M/S and the ms thousands/ones digits are never displayed.
   logic w_unused_bcd;
   assign w_unused_bcd = ^{r_bcd[0][15:8], r_bcd[1][15:8], r_bcd[2][15:8],
                           r_bcd[3][15:12], r_bcd[3][3:0]};

   // Display register: only a completed conversion is ever written.
   always_ff @(posedge clk) begin
      if (reset)         r_disp <= '0;
      else if (w_commit) r_disp <= w_disp_new;
   end

   // Scan divider and digit index; the index shown at a tick then advances.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= 3'd0;
      end else if (w_scan_tick) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= r_digit_idx + 3'd1;
      end else begin
         r_scan_cnt  <= r_scan_cnt + 1'b1;
      end
   end

   // Segment and decimal-point decode for the currently indexed digit.
   always_comb begin
      w_digit = r_disp[r_digit_idx];
      case (w_digit)
         4'd0:        w_seg_code = 7'b1000000;
         4'd1:        w_seg_code = 7'b1111001;
         4'd2:        w_seg_code = 7'b0100100;
         4'd3:        w_seg_code = 7'b0110000;
         4'd4:        w_seg_code = 7'b0011001;
         4'd5:        w_seg_code = 7'b0010010;
         4'd6:        w_seg_code = 7'b0000010;
         4'd7:        w_seg_code = 7'b1111000;
         4'd8:        w_seg_code = 7'b0000000;
         4'd9:        w_seg_code = 7'b0010000;
         c_CODE_DASH: w_seg_code = c_SEG_DASH;
         default:     w_seg_code = c_SEG_BLANK;
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      if ((r_digit_idx == 3'd7) && (w_digit == 4'd0)) w_seg_code = c_SEG_BLANK;
`endif
      w_dp_code = ~((r_digit_idx == 3'd6) || (r_digit_idx == 3'd4) || (r_digit_idx == 3'd2));
   end

   // Registered display drive: blanking wins immediately, otherwise update on a tick.
   always_ff @(posedge clk) begin
      if (reset || bus.blank_i) begin
         r_an  <= 8'hFF;
         r_seg <= c_SEG_BLANK;
         r_dp  <= 1'b1;
      end else if (w_scan_tick) begin
         r_an  <= ~(8'd1 << r_digit_idx);
         r_seg <= w_seg_code;
         r_dp  <= w_dp_code;
      end
   end

   assign bus.an_o   = r_an;
   assign bus.seg_o  = r_seg;
   assign bus.dp_o   = r_dp;
   assign bus.busy_o = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_time_display_scan.sv
`default_nettype none
//==============================================================================
// Module      : tb_time_display_scan
// Description : Randomized scoreboard bench for time_display_scan. A
//               cycle-level reference model built from decimal arithmetic
//               queues the expected display/busy state for every cycle; a
//               monitor pops and compares on each falling edge.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_time_display_scan;
    localparam int SCAN_DIV    = 4;
    localparam int CONV_PERIOD = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    time_display_scan_if bus();

    time_display_scan #(.SCAN_DIV(SCAN_DIV), .CONV_PERIOD(CONV_PERIOD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       busy;
    } exp_t;

    exp_t  sb_q[$];
    int    cyc      = 0;
    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "reset";

    int         m_k      = 0;
    int         m_idx    = 0;
    int         m_start  = 0;
    bit         m_active = 0;
    int         m_disp[8];
    int         m_pend[8];
    logic [7:0] m_an     = 8'hFF;
    logic [6:0] m_seg    = 7'h7F;
    logic       m_dp     = 1'b1;

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            10:      return 7'b0111111;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] expected_seg(int idx, int d);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 7 && d == 0) return 7'h7F;
`endif
        return seg_of(d);
    endfunction

    task automatic compute_pending();
        int h, m, s, ms;
        h  = int'(bus.Hours_i);
        m  = int'(bus.Minutes_i);
        s  = int'(bus.Seconds_i);
        ms = int'(bus.Milli_i);
        m_pend[7] = (h > 99) ? 10 : h / 10;
        m_pend[6] = (h > 99) ? 10 : h % 10;
        m_pend[5] = (m > 99) ? 10 : m / 10;
        m_pend[4] = (m > 99) ? 10 : m % 10;
        m_pend[3] = (s > 99) ? 10 : s / 10;
        m_pend[2] = (s > 99) ? 10 : s % 10;
        m_pend[1] = (ms > 999) ? 10 : ms / 100;
        m_pend[0] = (ms > 999) ? 10 : (ms / 10) % 10;
    endtask

    task automatic step();
        exp_t e;
        bit   scan_tick;
        if (reset) begin
            m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
            m_k = 0; m_idx = 0; m_active = 0;
            for (int i = 0; i < 8; i++) m_disp[i] = 0;
        end else begin
            scan_tick = ((m_k % SCAN_DIV) == SCAN_DIV - 1);
            if (bus.blank_i) begin
                m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
            end else if (scan_tick) begin
                m_an  = 8'hFF ^ (8'd1 << m_idx);
                m_seg = expected_seg(m_idx, m_disp[m_idx]);
                m_dp  = !(m_idx == 2 || m_idx == 4 || m_idx == 6);
            end
            if (scan_tick) m_idx = (m_idx + 1) % 8;
            if (m_active && m_k == m_start + 14) begin
                for (int i = 0; i < 8; i++) m_disp[i] = m_pend[i];
                m_active = 0;
            end else if (!m_active && (m_k % CONV_PERIOD) == CONV_PERIOD - 1) begin
                m_active = 1;
                m_start  = m_k;
                compute_pending();
            end
            m_k++;
        end
        @(posedge clk);
        #1;
        cyc++;
        e.cyc = cyc; e.an = m_an; e.seg = m_seg; e.dp = m_dp; e.busy = m_active;
        sb_q.push_back(e);
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic set_in(int h, int m, int s, int ms);
        bus.Hours_i   = 8'(h);
        bus.Minutes_i = 8'(m);
        bus.Seconds_i = 8'(s);
        bus.Milli_i   = 12'(ms);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            if ({bus.an_o, bus.seg_o, bus.dp_o, bus.busy_o} === {e.an, e.seg, e.dp, e.busy})
                n_pass++;
            else
                $display("FAIL %s cyc=%0d: got an=%h seg=%b dp=%b busy=%b, expected an=%h seg=%b dp=%b busy=%b",
                         phase, e.cyc, bus.an_o, bus.seg_o, bus.dp_o, bus.busy_o,
                         e.an, e.seg, e.dp, e.busy);
        end
    end

    initial begin
        int h, m, s, ms;
        int w;
        for (int i = 0; i < 8; i++) begin m_disp[i] = 0; m_pend[i] = 0; end
        set_in(0, 0, 0, 0);
        bus.blank_i = 1'b0;

        phase = "reset";
        reset = 1'b1;
        run(2);
        n_checks++;
        if ({bus.an_o, bus.seg_o, bus.dp_o, bus.busy_o} === {8'hFF, 7'h7F, 1'b1, 1'b0})
            n_pass++;
        else
            $display("FAIL reset state: an=%h seg=%b dp=%b busy=%b",
                     bus.an_o, bus.seg_o, bus.dp_o, bus.busy_o);
        reset = 1'b0;
        phase = "first_scan";
        run(12);

        phase = "h12_m34_s56_ms789";
        set_in(12, 34, 56, 789);
        run(90);

        phase = "wait_busy";
        w = 0;
        while (!bus.busy_o && w < 2 * CONV_PERIOD) begin
            step();
            w++;
        end
        n_checks++;
        if (bus.busy_o === 1'b1)
            n_pass++;
        else
            $display("FAIL wait_busy: busy_o did not rise within %0d cycles", 2 * CONV_PERIOD);

        phase = "out_of_range";
        set_in(100, $urandom_range(0, 59), 59, 1000);
        run(80);

        phase = "reset_mid_shift";
        set_in(23, 45, 7, 321);
        while ((m_k % CONV_PERIOD) != CONV_PERIOD - 1) step();
        step();
        repeat (6) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(60);

        phase = "hours_5_leading";
        set_in(5, 0, 1, 80);
        run(80);
        phase = "blank";
        bus.blank_i = 1'b1;
        run(8);
        bus.blank_i = 1'b0;
        run(16);

        for (int r = 0; r < 14; r++) begin
            phase = "random";
            h  = ($urandom_range(0, 4) == 0) ? $urandom_range(100, 255)  : $urandom_range(0, 23);
            m  = ($urandom_range(0, 6) == 0) ? $urandom_range(100, 255)  : $urandom_range(0, 59);
            s  = ($urandom_range(0, 6) == 0) ? $urandom_range(100, 255)  : $urandom_range(0, 59);
            ms = ($urandom_range(0, 4) == 0) ? $urandom_range(1000, 4095) : $urandom_range(0, 999);
            set_in(h, m, s, ms);
            run($urandom_range(20, 70));
            if ($urandom_range(0, 3) == 0) begin
                bus.blank_i = 1'b1;
                run($urandom_range(1, 6));
                bus.blank_i = 1'b0;
            end
            if (r == 7) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
        end
        run(60);

        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
